// File: rtl/instr_prefetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_prefetch_pkg
// Shared definitions for the instruction prefetch unit:
//   - pf_state_e   : prefetch FSM state encodings (2 bits)
//   - PF_DEFAULT_DEPTH : default FIFO depth
//   - PF_RESET_VECTOR  : fetch pointer value after reset
//   - cnt_bits()   : width of an occupancy counter that can hold 0..depth
// -----------------------------------------------------------------------------
package instr_prefetch_pkg;

  typedef enum logic [1:0] {
    PF_RUN      = 2'd0,  // issuing allowed
    PF_FULL     = 2'd1,  // FIFO plus outstanding request fill every slot
    PF_WAIT_BUS = 2'd2,  // CPU load/store owns the memory port
    PF_HALT     = 2'd3   // CPU halted; only a redirect restarts fetching
  } pf_state_e;

  localparam int PF_DEFAULT_DEPTH = 4;
  localparam int PF_RESET_VECTOR  = 0;

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_if
// Bundles the memory-port and fetch-stage signals of the prefetch unit.
//   master : prefetch unit side (drives mem_addr/mem_rd and the ir_* head)
//   slave  : CPU/memory side (drives read data, bus ownership, consume,
//            redirect and halt)
// -----------------------------------------------------------------------------
interface instr_prefetch_if #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16
);

  // Memory port
  logic [BITS_ADDR-1:0] mem_addr;
  logic                 mem_rd;
  logic [BITS_DATA-1:0] mem_rdata;
  logic                 mem_busy;

  // Fetch-stage port
  logic                 ir_valid;
  logic [BITS_DATA-1:0] ir_data;
  logic [BITS_ADDR-1:0] ir_pc;
  logic                 ir_ready;

  // Control-flow
  logic                 redirect;
  logic [BITS_ADDR-1:0] redirect_pc;
  logic                 halt;

  modport master (
    output mem_addr, mem_rd, ir_valid, ir_data, ir_pc,
    input  mem_rdata, mem_busy, ir_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  mem_addr, mem_rd, ir_valid, ir_data, ir_pc,
    output mem_rdata, mem_busy, ir_ready, redirect, redirect_pc, halt
  );

endinterface

// File: rtl/instr_prefetch_pf_fifo.sv
// -----------------------------------------------------------------------------
// pf_fifo
// Circular buffer of WIDTH-bit entries with push/pop/clear and occupancy.
// Ports:
//   clk, reset (async, active-low)
//   clear  : empty the buffer (wins over push and pop)
//   push   : write wdata at the tail (ignored when full without a pop)
//   pop    : advance the head (ignored when empty)
//   rdata  : head entry, zero while empty
//   count  : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module pf_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = PF_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [cnt_bits(DEPTH)-1:0] count
);

  localparam int CW = cnt_bits(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: non-blocking assignments in clocked processes so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_W'(1);
      if (do_pop)  head <= head + PTR_W'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; an empty buffer never exposes it
  // because rdata is masked to zero until count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clear) storage[tail] <= wdata;
  end

  assign rdata = (count != '0) ? storage[head] : '0;

endmodule

// File: rtl/instr_prefetch.sv
// -----------------------------------------------------------------------------
// instr_prefetch
// Reads sequential instruction words ahead of the CPU fetch stage into a
// small FIFO of {data, pc}. Yields the memory port whenever mem_busy is high,
// flushes on redirect (taken jump) and stops issuing on halt.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : instr_prefetch_if.master (memory port, ir_* head, redirect, halt)
//   perf_flushes / perf_stalls : 16-bit saturating event counters, present
//            only when PREFETCH_PERF_EN is defined
// Memory reads return data exactly one cycle after mem_rd.
// -----------------------------------------------------------------------------
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int DEPTH     = PF_DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_prefetch_if.master       bus
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]            perf_flushes,
  output logic [15:0]            perf_stalls
`endif
);

  localparam int CW = cnt_bits(DEPTH);
  localparam int PW = BITS_DATA + BITS_ADDR;

  pf_state_e            state, state_next;
  logic [BITS_ADDR-1:0] fpc, fpc_next;
  logic [BITS_ADDR-1:0] issue_pc;   // address of the request now in flight
  logic                 inflight;
  logic                 squash;
  logic [CW-1:0]        count, count_next, occ, occ_next;
  logic                 issue, push, pop;
  logic [PW-1:0]        head;

  // Occupancy counts the outstanding request so a response always has a slot.
  assign occ = count + CW'(inflight);

  // reset gates issue so mem_rd reads 0 while reset is held.
  assign issue = reset && (state != PF_HALT) && !bus.mem_busy &&
                 !bus.redirect && (occ < CW'(DEPTH));

  // A response landing in a redirect cycle belongs to the old path.
  assign push = inflight && !squash && !bus.redirect;
  assign pop  = bus.ir_valid && bus.ir_ready && !bus.redirect;

  assign count_next = bus.redirect ? '0 : count + CW'(push) - CW'(pop);
  assign occ_next   = count_next + CW'(issue);

  // NOTE: every signal written here gets a default first so no path through
  // the block leaves a value unassigned and infers a latch.
  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    if (bus.redirect)                     state_next = PF_RUN;
    else if (state == PF_HALT)            state_next = PF_HALT;
    else if (bus.halt)                    state_next = PF_HALT;
    else if (bus.mem_busy)                state_next = PF_WAIT_BUS;
    else if (occ_next == CW'(DEPTH))      state_next = PF_FULL;
    else                                  state_next = PF_RUN;

    if (bus.redirect)   fpc_next = bus.redirect_pc;
    else if (issue)     fpc_next = fpc + BITS_ADDR'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PF_RUN;
      fpc      <= BITS_ADDR'(PF_RESET_VECTOR);
      issue_pc <= '0;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      state    <= state_next;
      fpc      <= fpc_next;
      // Every request resolves in the following cycle, so inflight simply
      // follows issue; squash lives for one cycle and marks the old path.
      inflight <= issue;
      squash   <= bus.redirect && inflight;
      if (issue) issue_pc <= fpc;
    end
  end

  pf_fifo #(
    .WIDTH(PW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clear(bus.redirect),
    .push (push),
    .pop  (pop),
    .wdata({bus.mem_rdata, issue_pc}),
    .rdata(head),
    .count(count)
  );

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = fpc;
  assign bus.ir_valid = (count != '0);
  assign bus.ir_data  = head[PW-1:BITS_ADDR];
  assign bus.ir_pc    = head[BITS_ADDR-1:0];

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_flushes <= '0;
      perf_stalls  <= '0;
    end else begin
      if (bus.redirect && (perf_flushes != 16'hFFFF))
        perf_flushes <= perf_flushes + 16'd1;
      if (((state == PF_FULL) || (state == PF_WAIT_BUS)) &&
          (perf_stalls != 16'hFFFF))
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule
